ofifo_drain_ctrl: RTL and testbench
===================================

// Module: ofifo_drain_ctrl
// PURPOSE
//  Sequences draining of the output FIFO (ofifo) into the psum SRAM after a PE-array pass.
//  - Issues single-beat ofifo reads and captures each col*psum_bw row.
//  - Writes rows to consecutive SRAM addresses from base_addr.
//  - Shares the SRAM write port through a req/gnt handshake.
//  Sits between the ofifo output and the psum SRAM; started by the core-level controller.
// PARAMETERS
//  col      8   columns per ofifo row
//  psum_bw  16  bits per psum
//  addr_bw  11  SRAM address width
//  cnt_bw   7   width of word count; max drain is 2**cnt_bw-1 rows
// PORTS
//  clk          in   1              clock, rising edge
//  reset        in   1              synchronous, active-high
//  start        in   1              1-cycle pulse; begin drain (ignored unless IDLE)
//  base_addr    in   addr_bw        first SRAM address, sampled on accepted start
//  num_words    in   cnt_bw         rows to drain, sampled on accepted start
//  ofifo_valid  in   1              ofifo o_valid (last-column FIFO non-empty)
//  ofifo_out    in   col*psum_bw    ofifo out (head row)
//  ofifo_rd     out  1              ofifo rd request
//  sram_req     out  1              request for SRAM write port
//  sram_gnt     in   1              port granted this cycle
//  sram_cen     out  1              SRAM chip enable, active-low
//  sram_wen     out  1              SRAM write enable, active-low
//  sram_addr    out  addr_bw        SRAM address
//  sram_d       out  col*psum_bw    SRAM write data
//  busy         out  1              high in any state except IDLE
//  done         out  1              1-cycle pulse when drain completes
//  words_done   out  cnt_bw         rows written in the current/last drain
// BEHAVIOUR
//  Reset: state=IDLE; ofifo_rd=0, sram_req=0, sram_cen=1, sram_wen=1, sram_addr=0,
//   sram_d=0, busy=0, done=0, words_done=0. Reset mid-drain aborts at once; no partial write.
//  ofifo timing: rd sampled at edge E, ofifo registers it. Head row is on ofifo_out during
//   cycle E+1 and is popped at the end of E+1.
//  FSM, all outputs registered:
//   IDLE : start && num_words!=0 -> REQ; latch addr=base_addr, remaining=num_words,
//          words_done=0.
//          start && num_words==0 -> stay IDLE; done=1 next cycle.
//   REQ  : ofifo_valid=1 -> ofifo_rd=1 for exactly one cycle, -> WAIT.
//          ofifo_valid=0 -> hold (ofifo_rd=0), no timeout.
//   WAIT : ofifo_rd=0; one cycle while ofifo asserts its internal rd_en, -> CAPT.
//   CAPT : register ofifo_out into data reg; -> WRITE.
//   WRITE: sram_req=1.
//          sram_gnt=1 -> drive sram_cen=0, sram_wen=0, sram_addr=addr, sram_d=data reg
//          for exactly that cycle; addr+=1 (wraps mod 2**addr_bw); words_done+=1;
//          remaining-=1; -> REQ if remaining!=0, else DONE.
//          sram_gnt=0 -> hold; sram_cen=sram_wen=1.
//   DONE : done=1 for one cycle; -> IDLE. words_done holds until the next accepted start.
//  - Never more than one ofifo read outstanding; ofifo_rd never asserts in WAIT/CAPT/WRITE.
//  - start while busy is ignored and does not re-sample inputs.
//  - Minimum cost is 4 cycles/row (REQ, WAIT, CAPT, WRITE) with gnt and valid always high.
//  - sram_req drops in the cycle after the granted write.
//  - sram_addr/sram_d hold their last values when cen=1.
// TESTING
//  1. num_words=4, base=0x010, valid & gnt always 1 -> 4 writes at 0x010..0x013 with data
//     in FIFO order, one every 4 cycles; done pulse; words_done=4.
//  2. start with num_words=0 -> no ofifo_rd, no SRAM write; done 1 cycle later;
//     busy stays 0.
//  3. ofifo_valid low 10 cycles mid-drain -> ofifo_rd stays 0 and FSM holds in REQ;
//     resumes with no lost or duplicated rows.
//  4. sram_gnt low 5 cycles in WRITE -> sram_req=1, cen=wen=1 throughout;
//     write happens on the gnt cycle.
//  5. base=0x7FE, num_words=3 -> addresses 0x7FE, 0x7FF, 0x000.
//  6. reset asserted in CAPT of row 2 -> all outputs at reset values next cycle;
//     a new start then drains correctly.

Source files
------------

// File: rtl/ofifo_drain_ctrl.sv
// Drains rows from the output FIFO into the psum SRAM, one single-beat read per row,
// arbitrating for the SRAM write port with a req/gnt handshake.
module ofifo_drain_ctrl #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_bw = 11,
   parameter int cnt_bw  = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [addr_bw-1:0]       base_addr,
   input  logic [cnt_bw-1:0]        num_words,
   input  logic                     ofifo_valid,
   input  logic [col*psum_bw-1:0]   ofifo_out,
   output logic                     ofifo_rd,
   output logic                     sram_req,
   input  logic                     sram_gnt,
   output logic                     sram_cen,
   output logic                     sram_wen,
   output logic [addr_bw-1:0]       sram_addr,
   output logic [col*psum_bw-1:0]   sram_d,
   output logic                     busy,
   output logic                     done,
   output logic [cnt_bw-1:0]        words_done
);

   // state | meaning
   // IDLE  | waiting for start
   // REQ   | waiting for ofifo_valid, then issue one read
   // WAIT  | ofifo registers the read
   // CAPT  | head row on ofifo_out, captured into data_reg
   // WRITE | requesting the SRAM port; write fires in the gnt cycle
   // DONE  | one-cycle completion pulse
   typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPT, WRITE, DONE} state_t;

   localparam int row_bw = col*psum_bw;

   state_t              state, state_nxt;
   logic [addr_bw-1:0]  addr, addr_nxt, addr_last;
   logic [cnt_bw-1:0]   remaining, remaining_nxt, words_done_nxt;
   logic [row_bw-1:0]   data_reg, data_last;
   logic                ofifo_rd_nxt, sram_req_nxt, done_nxt;
   logic                wr_fire;

   assign wr_fire = (state == WRITE) && sram_gnt;

   always_comb begin
      state_nxt      = state;
      addr_nxt       = addr;
      remaining_nxt  = remaining;
      words_done_nxt = words_done;
      done_nxt       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (num_words != '0) begin
                  state_nxt      = REQ;
                  addr_nxt       = base_addr;
                  remaining_nxt  = num_words;
                  words_done_nxt = '0;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         REQ:   if (ofifo_valid) state_nxt = WAIT;
         WAIT:  state_nxt = CAPT;
         CAPT:  state_nxt = WRITE;
         WRITE: begin
            if (sram_gnt) begin
               addr_nxt       = addr + 1'b1;
               words_done_nxt = words_done + 1'b1;
               remaining_nxt  = remaining - 1'b1;
               state_nxt      = (remaining == cnt_bw'(1)) ? DONE : REQ;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      ofifo_rd_nxt = (state == REQ) && ofifo_valid;
      sram_req_nxt = (state_nxt == WRITE);
      if (state_nxt == DONE) done_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= '0;
         remaining  <= '0;
         words_done <= '0;
         data_reg   <= '0;
         addr_last  <= '0;
         data_last  <= '0;
         ofifo_rd   <= 1'b0;
         sram_req   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         addr       <= addr_nxt;
         remaining  <= remaining_nxt;
         words_done <= words_done_nxt;
         ofifo_rd   <= ofifo_rd_nxt;
         sram_req   <= sram_req_nxt;
         busy       <= (state_nxt != IDLE);
         done       <= done_nxt;
         if (state == CAPT) data_reg <= ofifo_out;
         if (wr_fire) begin
            addr_last <= addr;
            data_last <= data_reg;
         end
      end
   end

   // The write lands in the granted cycle; address/data otherwise hold the last write.
   assign sram_cen  = ~wr_fire;
   assign sram_wen  = ~wr_fire;
   assign sram_addr = wr_fire ? addr     : addr_last;
   assign sram_d    = wr_fire ? data_reg : data_last;

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Randomized bench for ofifo_drain_ctrl: a show-ahead FIFO model feeds rows, and every
// SRAM write is checked against the expected (base+i, row i) sequence of the drain.
module tb_ofifo_drain_ctrl;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [10:0]   base_addr = '0;
   logic [6:0]    num_words = '0;
   logic          ofifo_valid = 1'b0;
   logic [127:0]  ofifo_out = '0;
   logic          ofifo_rd;
   logic          sram_req;
   logic          sram_gnt = 1'b1;
   logic          sram_cen;
   logic          sram_wen;
   logic [10:0]   sram_addr;
   logic [127:0]  sram_d;
   logic          busy;
   logic          done;
   logic [6:0]    words_done;

   ofifo_drain_ctrl #(.col(8), .psum_bw(16), .addr_bw(11), .cnt_bw(7)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .num_words(num_words), .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out),
      .ofifo_rd(ofifo_rd), .sram_req(sram_req), .sram_gnt(sram_gnt),
      .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_d(sram_d), .busy(busy), .done(done), .words_done(words_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int last_wr = -1;
   bit gap_chk = 1'b0;

   logic [127:0] fq[$];
   logic [10:0]  exp_addr[$];
   logic [127:0] exp_data[$];
   bit valid_en = 1'b1, valid_rand = 1'b0;
   bit gnt_low = 1'b0, gnt_rand = 1'b0;
   bit rd_q = 1'b0, pend = 1'b0, rd_prev = 1'b0;
   logic [127:0] popped;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // show-ahead ofifo: rd sampled at an edge, row popped at the end of the following cycle
   initial forever begin
      @(negedge clk);
      pend = rd_q;
      rd_q = ofifo_rd;
      @(posedge clk);
      #1;
      if (pend && fq.size() > 0) popped = fq.pop_front();
      ofifo_valid = valid_en && (fq.size() > 0) && (!valid_rand || $urandom_range(0, 2) != 0);
      ofifo_out   = (fq.size() > 0) ? fq[0] : '0;
   end

   initial forever begin
      @(posedge clk);
      #1;
      sram_gnt = gnt_low ? 1'b0 : (gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
   end

   // write monitor
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         chk("rd_single", 128'(ofifo_rd && rd_prev), 0);
         if (sram_cen == 1'b0) begin
            wr_cnt++;
            chk("wen_with_cen", 128'(sram_wen), 0);
            chk("req_during_write", 128'(sram_req), 1);
            if (exp_addr.size() == 0) begin
               chk("extra_write", 1, 0);
            end else begin
               chk("wr_addr", 128'(sram_addr), 128'(exp_addr.pop_front()));
               chk("wr_data", sram_d, exp_data.pop_front());
            end
            if (gap_chk && last_wr >= 0) chk("wr_gap", 128'(cyc - last_wr), 4);
            last_wr = cyc;
         end
      end
      rd_prev = ofifo_rd;
   end

   task automatic prep(input logic [10:0] b, input int n);
      logic [127:0] row;
      fq.delete();
      exp_addr.delete();
      exp_data.delete();
      for (int i = 0; i < n + 2; i++) begin
         row = {$urandom, $urandom, $urandom, $urandom};
         fq.push_back(row);
         if (i < n) begin
            exp_addr.push_back(b + 11'(i));
            exp_data.push_back(row);
         end
      end
   endtask

   task automatic kick(input logic [10:0] b, input logic [6:0] n);
      @(posedge clk);
      #1;
      start = 1'b1; base_addr = b; num_words = n;
      @(posedge clk);
      #1;
      start = 1'b0; base_addr = 11'($urandom); num_words = 7'($urandom);
   endtask

   task automatic wait_done(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      chk("done_seen", 128'(ok), 1);
   endtask

   task automatic after_done(input int n);
      chk("words_done", 128'(words_done), 128'(n));
      chk("busy_in_done", 128'(busy), 1);
      chk("exp_left", 128'(exp_addr.size()), 0);
      @(negedge clk);
      chk("done_pulse_len", 128'(done), 0);
      chk("busy_after", 128'(busy), 0);
      chk("words_done_hold", 128'(words_done), 128'(n));
   endtask

   task automatic check_rst_vals(input string p);
      chk({p, "_rd"},   128'(ofifo_rd), 0);
      chk({p, "_req"},  128'(sram_req), 0);
      chk({p, "_cen"},  128'(sram_cen), 1);
      chk({p, "_wen"},  128'(sram_wen), 1);
      chk({p, "_addr"}, 128'(sram_addr), 0);
      chk({p, "_d"},    sram_d, 0);
      chk({p, "_busy"}, 128'(busy), 0);
      chk({p, "_done"}, 128'(done), 0);
      chk({p, "_wd"},   128'(words_done), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, rd_seen, b, n;
      bit ok;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_rst_vals("rst");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // back-to-back drain, one write every 4 cycles
      prep(11'h010, 4);
      gap_chk = 1'b1; last_wr = -1;
      kick(11'h010, 7'd4);
      wait_done(100);
      after_done(4);
      gap_chk = 1'b0;

      // zero-length drain
      w0 = wr_cnt;
      kick(11'h055, 7'd0);
      @(negedge clk);
      chk("zero_done", 128'(done), 1);
      chk("zero_busy", 128'(busy), 0);
      rd_seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         if (ofifo_rd) rd_seen++;
      end
      @(negedge clk);
      chk("zero_done_off", 128'(done), 0);
      chk("zero_rd", 128'(rd_seen), 0);
      chk("zero_writes", 128'(wr_cnt - w0), 0);

      // ofifo_valid low for 10 cycles mid-drain
      prep(11'h100, 6);
      w0 = wr_cnt;
      kick(11'h100, 7'd6);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (wr_cnt != w0) ok = 1'b1;
      end
      chk("first_write_seen", 128'(ok), 1);
      valid_en = 1'b0;
      rd_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ofifo_rd || !sram_cen || !busy) rd_seen++;
      end
      chk("hold_in_req", 128'(rd_seen), 0);
      valid_en = 1'b1;
      wait_done(100);
      after_done(6);

      // grant withheld for 5 WRITE cycles
      prep(11'h200, 2);
      gnt_low = 1'b1;
      kick(11'h200, 7'd2);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (sram_req) ok = 1'b1;
      end
      chk("req_seen", 128'(ok), 1);
      rd_seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         if (!sram_req || !sram_cen || !sram_wen) rd_seen++;
      end
      chk("gnt_low_hold", 128'(rd_seen), 0);
      gnt_low = 1'b0;
      @(negedge clk);
      chk("write_on_gnt", 128'(sram_cen), 0);
      @(negedge clk);
      chk("req_drop_after_write", 128'(sram_req), 0);
      wait_done(100);
      after_done(2);

      // address wrap
      prep(11'h7FE, 3);
      kick(11'h7FE, 7'd3);
      wait_done(100);
      after_done(3);

      // reset during CAPT of row 2
      prep(11'h300, 5);
      w0 = wr_cnt;
      kick(11'h300, 7'd5);
      rd_seen = 0;
      for (int i = 0; i < 100 && rd_seen < 2; i++) begin
         @(negedge clk);
         if (ofifo_rd) rd_seen++;
      end
      chk("second_rd_seen", 128'(rd_seen), 2);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_rst_vals("abort");
      chk("abort_writes", 128'(wr_cnt - w0), 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      prep(11'h321, 5);
      kick(11'h321, 7'd5);
      wait_done(100);
      after_done(5);

      // random drains with random valid/gnt and a start while busy
      valid_rand = 1'b1;
      gnt_rand = 1'b1;
      for (int t = 0; t < 6; t++) begin
         b = $urandom_range(0, 2047);
         n = $urandom_range(2, 10);
         prep(11'(b), n);
         kick(11'(b), 7'(n));
         repeat (2) @(posedge clk);
         #1;
         start = 1'b1; base_addr = 11'($urandom); num_words = 7'($urandom_range(1, 20));
         @(posedge clk);
         #1;
         start = 1'b0;
         wait_done(400);
         after_done(n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
